// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    typedef enum logic [1:0] {
        RST   = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    localparam int OPCODE_MSB  = 31;
    localparam int OPCODE_LSB  = 26;
    localparam int FUNCT_MSB   = 5;
    localparam int FUNCT_LSB   = 0;
    localparam int FETCH_DEPTH = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO with single-cycle flush.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: none internally; the caller never pushes into a full queue without a pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [FETCH_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FETCH_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            // Storage is left as-is; only the occupancy is discarded.
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/mips_fetch_unit.sv
// MIPS fetch stage: owns the PC, issues imem reads, queues in-order responses for decode.
// Latency: response in cycle N is presented to decode in cycle N+1.
// Backpressure: requests stop while in-flight plus queued words reach 2; optional FETCH_PERF_CNT_EN adds counters.
module mips_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        dec_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [5:0]  opcode,
    output logic [5:0]  funct
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushes
`endif
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc;
    logic [1:0]   drop_cnt, drop_nxt;
    logic [1:0]   outstanding;
    logic [1:0]   fifo_count;
    logic         req_fire;
    logic         redir;
    logic         resp_keep;
    logic         resp_drop;
    logic         dec_fire;
    logic [31:0]  resp_pc;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;
    logic         unused_redir_lsb;

    assign unused_redir_lsb = ^redirect_pc[1:0];

    assign redir     = redirect_valid && (state != RST);
    assign resp_drop = imem_resp_valid && (drop_cnt != 2'd0);
    assign resp_keep = imem_resp_valid && (drop_cnt == 2'd0);

    // Credit covers both words still in memory and words waiting for decode.
    assign imem_req_valid = (state != RST) && !redirect_valid &&
                            (({1'b0, outstanding} + {1'b0, fifo_count}) < 3'd2);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign instr_valid = (fifo_count != 2'd0) && !redirect_valid;
    assign dec_fire    = instr_valid && dec_ready;
    assign instr       = head_entry.instr;
    assign instr_pc    = head_entry.pc;
    assign opcode      = head_entry.instr[OPCODE_MSB:OPCODE_LSB];
    assign funct       = head_entry.instr[FUNCT_MSB:FUNCT_LSB];

    assign push_entry = '{instr: imem_resp_data, pc: resp_pc};

    // Addresses of accepted requests, popped by every response (kept or dropped).
    fetch_fifo #(.WIDTH(32)) u_inflight (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (1'b0),
        .push     (req_fire),
        .push_dat (pc),
        .pop      (imem_resp_valid),
        .head_dat (resp_pc),
        .count    (outstanding)
    );

    fetch_fifo #(.WIDTH($bits(fetch_entry_t))) u_instr_q (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redir),
        .push     (resp_keep && !redir),
        .push_dat (push_entry),
        .pop      (dec_fire),
        .head_dat (head_entry),
        .count    (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RST;
            drop_cnt <= 2'd0;
        end else begin
            state    <= state_nxt;
            drop_cnt <= drop_nxt;
        end
    end

    // Everything still in flight at a redirect belongs to the old path.
    always_comb begin
        state_nxt = state;
        drop_nxt  = drop_cnt;
        if (state == RST) begin
            state_nxt = RUN;
        end else begin
            if (resp_drop) begin
                drop_nxt = drop_cnt - 2'd1;
            end
            if (redir) begin
                drop_nxt = outstanding - {1'b0, imem_resp_valid};
            end
            state_nxt = (drop_nxt != 2'd0) ? FLUSH : RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redir) begin
            pc <= {redirect_pc[31:2], 2'b00};
        end else if (req_fire) begin
            pc <= pc + 32'd4;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= 32'd0;
            perf_flushes <= 32'd0;
        end else begin
            if (dec_fire) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (redirect_valid) begin
                perf_flushes <= perf_flushes + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Randomized bench for mips_fetch_unit against a queue-based fetch model.
// Directed scenarios pin the model with literal values.
module tb_mips_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        dec_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [5:0]  opcode;
    logic [5:0]  funct;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushes;
`endif

    mips_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instr_valid     (instr_valid),
        .dec_ready       (dec_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .opcode          (opcode),
        .funct           (funct)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_flushes    (perf_flushes)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Memory environment: accepted addresses and the cycle they were accepted.
    logic [31:0] mem_addr_q[$];
    int          mem_cyc_q[$];

    // Reference model.
    bit          m_rst;
    logic [31:0] m_pc;
    logic [31:0] m_if_pc[$];
    bit          m_if_drop[$];
    logic [31:0] m_q_dat[$];
    logic [31:0] m_q_pc[$];
    logic [31:0] m_fetched;
    logic [31:0] m_flushes;

    // Outputs sampled in the most recent cycle.
    logic        s_req_valid, s_instr_valid;
    logic [31:0] s_req_addr, s_instr, s_instr_pc;
    logic [5:0]  s_opcode, s_funct;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RST_PC) return 32'h8C22_0004;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rst = 1'b1;
        m_pc  = RST_PC;
        m_if_pc.delete();
        m_if_drop.delete();
        m_q_dat.delete();
        m_q_pc.delete();
        mem_addr_q.delete();
        mem_cyc_q.delete();
        m_fetched = 32'd0;
        m_flushes = 32'd0;
    endtask

    task automatic idle_inputs();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'd0;
        dec_ready       = 1'b0;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input bit rdy, input bit resp_en, input bit dec,
                         input bit redir, input logic [31:0] tgt);
        bit          resp, exp_req, exp_iv, keep;
        logic [31:0] rpc;
        resp = resp_en && (mem_addr_q.size() > 0) && (mem_cyc_q[0] < cyc);
        imem_req_ready  = rdy;
        imem_resp_valid = resp;
        imem_resp_data  = resp ? mem_word(mem_addr_q[0]) : 32'hDEAD_BEEF;
        dec_ready       = dec;
        redirect_valid  = redir;
        redirect_pc     = tgt;
        #1;
        s_req_valid   = imem_req_valid;
        s_req_addr    = imem_req_addr;
        s_instr_valid = instr_valid;
        s_instr       = instr;
        s_instr_pc    = instr_pc;
        s_opcode      = opcode;
        s_funct       = funct;

        exp_req = !m_rst && !redir && ((m_if_pc.size() + m_q_dat.size()) < 2);
        exp_iv  = (m_q_dat.size() > 0) && !redir;
        chk("req_valid", imem_req_valid, exp_req);
        chk("req_addr", imem_req_addr, m_pc);
        chk("instr_valid", instr_valid, exp_iv);
        if (exp_iv) begin
            chk("instr", instr, m_q_dat[0]);
            chk("instr_pc", instr_pc, m_q_pc[0]);
            chk("opcode", opcode, m_q_dat[0] >> 26);
            chk("funct", funct, m_q_dat[0] & 32'h3F);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_flushes", perf_flushes, m_flushes);
`endif

        if (resp) begin
            void'(mem_addr_q.pop_front());
            void'(mem_cyc_q.pop_front());
        end
        if (imem_req_valid && rdy) begin
            mem_addr_q.push_back(imem_req_addr);
            mem_cyc_q.push_back(cyc);
        end

        keep = 1'b0;
        rpc  = 32'd0;
        if (resp && (m_if_pc.size() > 0)) begin
            rpc  = m_if_pc.pop_front();
            keep = !m_if_drop.pop_front() && !redir;
        end
        if (exp_iv && dec) begin
            void'(m_q_dat.pop_front());
            void'(m_q_pc.pop_front());
            m_fetched++;
        end
        if (keep) begin
            m_q_dat.push_back(mem_word(rpc));
            m_q_pc.push_back(rpc);
        end
        if (redir) begin
            m_q_dat.delete();
            m_q_pc.delete();
            foreach (m_if_drop[i]) m_if_drop[i] = 1'b1;
            m_pc = {tgt[31:2], 2'b00};
            m_flushes++;
        end else if (exp_req && rdy) begin
            m_if_pc.push_back(m_pc);
            m_if_drop.push_back(1'b0);
            m_pc = m_pc + 32'd4;
        end
        m_rst = 1'b0;
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_until_iv(input int budget, input bit rdy, input bit resp_en, input bit dec);
        for (int i = 0; i < budget; i++) begin
            cycle(rdy, resp_en, dec, 1'b0, 32'd0);
            if (s_instr_valid) break;
        end
        chk("wait_instr_valid", s_instr_valid, 1'b1);
    endtask

    task automatic run_until_req(input int budget);
        for (int i = 0; i < budget; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
            if (s_req_valid) break;
        end
        chk("wait_req_valid", s_req_valid, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        chk("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_opcode", opcode, 6'd0);
        chk("rst_funct", funct, 6'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        logic [31:0] tgt;

        do_reset();

        // First request in the 2nd cycle after release; 1-cycle memory.
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        chk("first_cycle_no_req", s_req_valid, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        chk("req0_valid", s_req_valid, 1'b1);
        chk("req0_addr", s_req_addr, 32'h0040_0000);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        chk("req1_valid", s_req_valid, 1'b1);
        chk("req1_addr", s_req_addr, 32'h0040_0004);
        run_until_iv(10, 1'b1, 1'b1, 1'b1);
        chk("lw_instr", s_instr, 32'h8C22_0004);
        chk("lw_opcode", s_opcode, 6'h23);
        chk("lw_funct", s_funct, 6'h04);
        chk("lw_pc", s_instr_pc, 32'h0040_0000);
        repeat (20) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);

        // Decode stall: requests stop and the head holds.
        repeat (6) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("stall_req_valid", s_req_valid, 1'b0);
        chk("stall_instr_valid", s_instr_valid, 1'b1);
        held = s_instr;
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("stall_instr_stable", s_instr, held);
        repeat (10) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);

        // Redirect with two requests outstanding; both responses are dropped.
        repeat (6) cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        chk("two_out_req_valid", s_req_valid, 1'b0);
        chk("two_out_instr_valid", s_instr_valid, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0040_0103);
        run_until_iv(20, 1'b1, 1'b1, 1'b1);
        chk("redir_first_pc", s_instr_pc, 32'h0040_0100);
        chk("redir_first_instr", s_instr, mem_word(32'h0040_0100));

        // PC wrap at the top of the address space.
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        run_until_req(10);
        chk("wrap_addr0", s_req_addr, 32'hFFFF_FFFC);
        run_until_req(10);
        chk("wrap_addr1", s_req_addr, 32'h0000_0000);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)
                tgt = $urandom();
            else
                tgt = RST_PC | ($urandom_range(0, 1023) << 2) | $urandom_range(0, 3);
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0), tgt);
        end

        // Asynchronous reset with a full queue.
        repeat (8) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("full_instr_valid", s_instr_valid, 1'b1);
        chk("full_req_valid", s_req_valid, 1'b0);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_instr_valid", instr_valid, 1'b0);
        chk("async_req_valid", imem_req_valid, 1'b0);
        chk("async_instr", instr, 32'd0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        chk("restart_req_valid", s_req_valid, 1'b1);
        chk("restart_addr", s_req_addr, RST_PC);
        repeat (10) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);

`ifdef FETCH_PERF_CNT_EN
        do_reset();
        for (int i = 0; i < 100 && m_fetched < 32'd10; i++)
            cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b1, RST_PC);
        chk("perf_fetched_10", perf_fetched, 32'd10);
        chk("perf_flushes_3", perf_flushes, 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
